// File: rtl/lsq_ordered.sv
// In-order load/store queue between the decoder/ROB and the data-cache port.
// Stores and MMIO loads wait for ROB head; load results are extended here.
module lsq_ordered #(
    parameter int          DEPTH_LOG = 3,
    parameter int          ROB_W     = 4,
    parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    output logic             full,
    input  logic             issue_valid,
    input  logic             issue_store,
    input  logic [2:0]       issue_op,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_v1,
    input  logic [31:0]      issue_v2,
    input  logic             issue_d1,
    input  logic             issue_d2,
    input  logic [ROB_W-1:0] issue_q1,
    input  logic [ROB_W-1:0] issue_q2,
    input  logic [ROB_W-1:0] issue_rob,
    input  logic             alu_ready,
    input  logic [ROB_W-1:0] alu_rob,
    input  logic [31:0]      alu_value,
    input  logic [ROB_W-1:0] head_rob,
    input  logic             flush,
    output logic             lsb_ready,
    output logic [ROB_W-1:0] lsb_rob,
    output logic [31:0]      lsb_value,
    input  logic             mem_grant,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       mem_op,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Returns {still_pending, value}; the ALU bus has priority over our own bus.
    function automatic logic [32:0] snoop(
        input logic             pend,
        input logic [31:0]      val,
        input logic [ROB_W-1:0] tag,
        input logic             a_rdy,
        input logic [ROB_W-1:0] a_tag,
        input logic [31:0]      a_val,
        input logic             l_rdy,
        input logic [ROB_W-1:0] l_tag,
        input logic [31:0]      l_val
    );
        logic [32:0] r;
        if (!pend) begin
            r = {1'b0, val};
        end else if (a_rdy && (a_tag == tag)) begin
            r = {1'b0, a_val};
        end else if (l_rdy && (l_tag == tag)) begin
            r = {1'b0, l_val};
        end else begin
            r = {1'b1, val};
        end
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] raw);
        logic [31:0] r;
        case (op)
            3'd0:    r = {{24{raw[7]}}, raw[7:0]};
            3'd1:    r = {{16{raw[15]}}, raw[15:0]};
            3'd4:    r = {24'd0, raw[7:0]};
            3'd5:    r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    state_e state_q, state_d;

    logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;

    logic [DEPTH-1:0] e_valid_q, e_valid_d;
    logic [DEPTH-1:0] e_store_q, e_store_d;
    logic [DEPTH-1:0] e_d1_q, e_d1_d;
    logic [DEPTH-1:0] e_d2_q, e_d2_d;
    logic [2:0]       e_op_q  [DEPTH];
    logic [2:0]       e_op_d  [DEPTH];
    logic [31:0]      e_imm_q [DEPTH];
    logic [31:0]      e_imm_d [DEPTH];
    logic [31:0]      e_v1_q  [DEPTH];
    logic [31:0]      e_v1_d  [DEPTH];
    logic [31:0]      e_v2_q  [DEPTH];
    logic [31:0]      e_v2_d  [DEPTH];
    logic [ROB_W-1:0] e_q1_q  [DEPTH];
    logic [ROB_W-1:0] e_q1_d  [DEPTH];
    logic [ROB_W-1:0] e_q2_q  [DEPTH];
    logic [ROB_W-1:0] e_q2_d  [DEPTH];
    logic [ROB_W-1:0] e_rob_q [DEPTH];
    logic [ROB_W-1:0] e_rob_d [DEPTH];

    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [2:0]       mem_op_q, mem_op_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [ROB_W-1:0] infl_rob_q, infl_rob_d;

    logic [31:0] head_addr_s;
    logic        head_ok_s;
    logic        launch_s;
    logic        push_s;

    assign full      = (count_q == DEPTH_CNT);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // A flush in the done cycle suppresses the broadcast of the op it kills.
    assign lsb_ready = mem_done && (state_q == ST_BUSY) && !(rdy && flush);
    assign lsb_rob   = lsb_ready ? infl_rob_q : {ROB_W{1'b0}};
    assign lsb_value = (lsb_ready && !mem_we_q) ? load_extend(mem_op_q, mem_rdata) : 32'd0;

    assign head_addr_s = e_v1_q[head_q] + e_imm_q[head_q];
    assign head_ok_s   = (!e_store_q[head_q] && (head_addr_s < IO_BASE))
                       || (e_rob_q[head_q] == head_rob);
    assign launch_s    = rdy && !flush && (state_q == ST_IDLE) && mem_grant
                       && e_valid_q[head_q] && !e_d1_q[head_q] && !e_d2_q[head_q] && head_ok_s;
    assign push_s      = rdy && issue_valid && !full && !flush;

    // Port FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) state_d = ST_BUSY;
                else          state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (mem_done)   state_d = ST_IDLE;
                else if (flush) state_d = ST_DRAIN;
                else            state_d = ST_BUSY;
            end
            ST_DRAIN: begin
                if (mem_done) state_d = ST_IDLE;
                else          state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields: loaded at launch, held until the done pulse.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        infl_rob_d  = infl_rob_q;
        if (launch_s) begin
            mem_req_d   = 1'b1;
            mem_we_d    = e_store_q[head_q];
            mem_op_d    = e_op_q[head_q];
            mem_addr_d  = head_addr_s;
            mem_wdata_d = e_store_q[head_q] ? e_v2_q[head_q] : 32'd0;
            infl_rob_d  = e_rob_q[head_q];
        end else if ((state_q != ST_IDLE) && mem_done) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_op_d    = 3'd0;
            mem_addr_d  = 32'd0;
            mem_wdata_d = 32'd0;
        end else begin
            mem_req_d   = mem_req_q;
        end
    end

    // FIFO pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {DEPTH_LOG{1'b0}};
            tail_d  = {DEPTH_LOG{1'b0}};
            count_d = {(DEPTH_LOG + 1){1'b0}};
        end else begin
            if (launch_s) head_d = head_q + 1'b1;
            if (push_s)   tail_d = tail_q + 1'b1;
            if (push_s && !launch_s)      count_d = count_q + 1'b1;
            else if (launch_s && !push_s) count_d = count_q - 1'b1;
            else                          count_d = count_q;
        end
    end

    // Entry storage: operand wakeup, pop at launch, push at tail, flush.
    always_comb begin
        e_valid_d = e_valid_q;
        e_store_d = e_store_q;
        e_d1_d    = e_d1_q;
        e_d2_d    = e_d2_q;
        e_op_d    = e_op_q;
        e_imm_d   = e_imm_q;
        e_v1_d    = e_v1_q;
        e_v2_d    = e_v2_q;
        e_q1_d    = e_q1_q;
        e_q2_d    = e_q2_q;
        e_rob_d   = e_rob_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid_q[i]) begin
                {e_d1_d[i], e_v1_d[i]} = snoop(e_d1_q[i], e_v1_q[i], e_q1_q[i],
                                               alu_ready, alu_rob, alu_value,
                                               lsb_ready, lsb_rob, lsb_value);
                {e_d2_d[i], e_v2_d[i]} = snoop(e_d2_q[i], e_v2_q[i], e_q2_q[i],
                                               alu_ready, alu_rob, alu_value,
                                               lsb_ready, lsb_rob, lsb_value);
            end
        end
        if (launch_s) e_valid_d[head_q] = 1'b0;
        if (push_s) begin
            e_valid_d[tail_q] = 1'b1;
            e_store_d[tail_q] = issue_store;
            e_op_d[tail_q]    = issue_op;
            e_imm_d[tail_q]   = issue_imm;
            e_q1_d[tail_q]    = issue_q1;
            e_q2_d[tail_q]    = issue_q2;
            e_rob_d[tail_q]   = issue_rob;
            {e_d1_d[tail_q], e_v1_d[tail_q]} = snoop(issue_d1, issue_v1, issue_q1,
                                                     alu_ready, alu_rob, alu_value,
                                                     lsb_ready, lsb_rob, lsb_value);
            {e_d2_d[tail_q], e_v2_d[tail_q]} = snoop(issue_d2, issue_v2, issue_q2,
                                                     alu_ready, alu_rob, alu_value,
                                                     lsb_ready, lsb_rob, lsb_value);
        end
        if (flush) e_valid_d = {DEPTH{1'b0}};
    end

    // Control and port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            head_q      <= {DEPTH_LOG{1'b0}};
            tail_q      <= {DEPTH_LOG{1'b0}};
            count_q     <= {(DEPTH_LOG + 1){1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_op_q    <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            infl_rob_q  <= {ROB_W{1'b0}};
        end else if (rdy) begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            infl_rob_q  <= infl_rob_d;
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= {DEPTH{1'b0}};
            e_store_q <= {DEPTH{1'b0}};
            e_d1_q    <= {DEPTH{1'b0}};
            e_d2_q    <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                e_op_q[i]  <= 3'd0;
                e_imm_q[i] <= 32'd0;
                e_v1_q[i]  <= 32'd0;
                e_v2_q[i]  <= 32'd0;
                e_q1_q[i]  <= {ROB_W{1'b0}};
                e_q2_q[i]  <= {ROB_W{1'b0}};
                e_rob_q[i] <= {ROB_W{1'b0}};
            end
        end else if (rdy) begin
            e_valid_q <= e_valid_d;
            e_store_q <= e_store_d;
            e_d1_q    <= e_d1_d;
            e_d2_q    <= e_d2_d;
            e_op_q    <= e_op_d;
            e_imm_q   <= e_imm_d;
            e_v1_q    <= e_v1_d;
            e_v2_q    <= e_v2_d;
            e_q1_q    <= e_q1_d;
            e_q2_q    <= e_q2_d;
            e_rob_q   <= e_rob_d;
        end
    end

endmodule
